// File: rtl/ef_sram_arbiter_if.sv
// ef_sram_arbiter_if: classic single-word Wishbone slave port, one instance per master.
interface ef_sram_arbiter_if #(
    parameter int AW = 11
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [3:0]    sel;
    logic [AW+1:0] adr;
    logic [31:0]   dat_w;
    logic [31:0]   dat_r;
    logic          ack;
    modport master(output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
    modport slave(input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/ef_sram_arbiter.sv
// ef_sram_arbiter: two-master Wishbone arbiter sequencing one shared ef_sram bank (IDLE/CMD/RESP).
// Define EF_SRAM_ARB_FIXED_PRIO_EN to let m0 win every tie instead of round-robin.
module ef_sram_arbiter #(
    parameter int RAM_BLOCKS = 2,
    localparam int AW = $clog2(RAM_BLOCKS) + 10
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    ef_sram_arbiter_if.slave m0,
    ef_sram_arbiter_if.slave m1,
    output logic             sram_en,
    output logic             sram_r_wb,
    output logic [AW-1:0]    sram_ad,
    output logic [31:0]      sram_ben,
    output logic [31:0]      sram_di,
    input  logic [31:0]      sram_do,
    output logic             sram_tm,
    output logic             sram_sm,
    output logic             sram_wlbi,
    output logic             sram_wloff
);
    localparam logic [AW:0] DEPTH = (AW + 1)'(RAM_BLOCKS * 1024);
    typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;
    state_t state, state_nx;
    logic gnt, gnt_nx, last, last_nx, oor, oor_nx;
    logic req0, req1, tie_gnt, pick, we, unused_adr;
    logic [3:0] sel;
    logic [AW-1:0] pick_ad, ad;
    logic [31:0] dat, rd;
    assign req0 = m0.cyc & m0.stb;
    assign req1 = m1.cyc & m1.stb;
`ifdef EF_SRAM_ARB_FIXED_PRIO_EN
    assign tie_gnt = 1'b0;
`else
    assign tie_gnt = ~last;
`endif
    assign pick = (req0 & req1) ? tie_gnt : req1;
    assign pick_ad = pick ? m1.adr[AW+1:2] : m0.adr[AW+1:2];
    assign we = gnt ? m1.we : m0.we;
    assign sel = gnt ? m1.sel : m0.sel;
    assign ad = gnt ? m1.adr[AW+1:2] : m0.adr[AW+1:2];
    assign dat = gnt ? m1.dat_w : m0.dat_w;
    assign rd = oor ? 32'h0 : sram_do;
    assign unused_adr = ^{m0.adr[1:0], m1.adr[1:0]};
    assign sram_tm = 1'b0;
    assign sram_sm = 1'b0;
    assign sram_wlbi = 1'b0;
    assign sram_wloff = 1'b0;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            gnt <= 1'b0;
            last <= 1'b1;
            oor <= 1'b0;
        end else begin
            state <= state_nx;
            gnt <= gnt_nx;
            last <= last_nx;
            oor <= oor_nx;
        end
    end
    // The SRAM pins are only non-zero in CMD; a master dropping cyc there still completes the access.
    always_comb begin
        state_nx = state;
        gnt_nx = gnt;
        last_nx = last;
        oor_nx = oor;
        sram_en = 1'b0;
        sram_r_wb = 1'b0;
        sram_ad = '0;
        sram_ben = '0;
        sram_di = '0;
        m0.ack = 1'b0;
        m1.ack = 1'b0;
        m0.dat_r = '0;
        m1.dat_r = '0;
        unique case (state)
            IDLE: if (req0 | req1) begin
                state_nx = CMD;
                gnt_nx = pick;
                last_nx = pick;
                oor_nx = {1'b0, pick_ad} >= DEPTH;
            end
            CMD: begin
                state_nx = RESP;
                sram_en = ~oor;
                sram_r_wb = ~we;
                sram_ad = ad;
                sram_ben = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
                sram_di = dat;
            end
            RESP: begin
                state_nx = IDLE;
                m0.ack = ~gnt & m0.cyc;
                m1.ack = gnt & m1.cyc;
                m0.dat_r = gnt ? 32'h0 : rd;
                m1.dat_r = gnt ? rd : 32'h0;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ef_sram_arbiter.sv
// tb_ef_sram_arbiter: table vectors, corner sequences and random traffic against a word-level model.
// Built with RAM_BLOCKS=3 so word addresses 3072..4095 exercise the out-of-range path.
module tb_ef_sram_arbiter;
    localparam int AW = 12;
`ifdef EF_SRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    typedef struct {
        bit          v;
        bit          we;
        logic [13:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } req_t;
    typedef struct {
        bit          m;
        bit          we;
        logic [13:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        bit          en;
        logic [11:0] ad;
        logic [31:0] ben;
        logic [31:0] rd;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1;
    logic sram_en, sram_r_wb, sram_tm, sram_sm, sram_wlbi, sram_wloff;
    logic [AW-1:0] sram_ad;
    logic [31:0] sram_ben, sram_di;
    logic [31:0] sram_do = '0;
    logic [31:0] mem [0:4095] = '{default: '0};
    logic [31:0] ref_mem [0:4095] = '{default: '0};
    int passed = 0, total = 0, m_last = 1, cap_en_cnt;
    logic [31:0] cap_ben, cap_di, last_d [2];
    logic [11:0] cap_ad;
    logic cap_rwb;
    vec_t tbl [11];
    req_t none, r, a, b;
    int n, owner;
    ef_sram_arbiter_if #(.AW(AW)) m0 ();
    ef_sram_arbiter_if #(.AW(AW)) m1 ();
    ef_sram_arbiter #(.RAM_BLOCKS(3)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .m0(m0), .m1(m1),
        .sram_en(sram_en), .sram_r_wb(sram_r_wb), .sram_ad(sram_ad), .sram_ben(sram_ben),
        .sram_di(sram_di), .sram_do(sram_do), .sram_tm(sram_tm), .sram_sm(sram_sm),
        .sram_wlbi(sram_wlbi), .sram_wloff(sram_wloff)
    );
    always #5 clk = ~clk;
    // Behavioural ef_sram: read data appears the cycle after EN.
    always_ff @(posedge clk) begin
        if (sram_en && sram_r_wb) sram_do <= mem[sram_ad];
        if (sram_en && !sram_r_wb) mem[sram_ad] <= (mem[sram_ad] & ~sram_ben) | (sram_di & sram_ben);
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] res = o;
        for (int k = 0; k < 4; k++) if (s[k]) res[8*k +: 8] = d[8*k +: 8];
        return res;
    endfunction
    function automatic req_t rnd();
        req_t q;
        int p = $urandom_range(0, 9);
        logic [11:0] w = p < 5 ? 12'($urandom_range(0, 7)) : p < 8 ? 12'($urandom_range(0, 3071)) : 12'($urandom_range(3072, 4095));
        q.v = $urandom_range(0, 3) != 0;
        q.we = 1'($urandom_range(0, 1));
        q.sel = 4'($urandom_range(0, 15));
        q.dat = $urandom;
        q.adr = {w, 2'($urandom_range(0, 3))};
        return q;
    endfunction
    task automatic drive(input bit m, input req_t q);
        if (m) begin
            m1.cyc = q.v; m1.stb = q.v; m1.we = q.we; m1.sel = q.sel; m1.adr = q.adr; m1.dat_w = q.dat;
        end else begin
            m0.cyc = q.v; m0.stb = q.v; m0.we = q.we; m0.sel = q.sel; m0.adr = q.adr; m0.dat_w = q.dat;
        end
    endtask
    // One arbitration round: the model orders the requesters, predicts ack cycles, data and SRAM enables.
    task automatic run(input req_t q0, input req_t q1, input bit drop);
        req_t q [2];
        int ord [$];
        int exp_ack [2], got_ack [2];
        int exp_en, f;
        logic [31:0] exp_d [2], got_d [2];
        logic [11:0] w;
        q[0] = q0; q[1] = q1;
        f = (q0.v && q1.v) ? (FIXED ? 0 : 1 - m_last) : (q1.v ? 1 : 0);
        if (q[f].v) ord.push_back(f);
        if (q[1-f].v) ord.push_back(1 - f);
        exp_ack = '{-1, -1}; got_ack = '{-1, -1};
        exp_d = '{32'h0, 32'h0}; got_d = '{32'h0, 32'h0};
        exp_en = 0;
        foreach (ord[i]) begin
            w = q[ord[i]].adr[13:2];
            m_last = ord[i];
            exp_ack[ord[i]] = (drop && ord[i] == 0) ? -1 : 2 + 3 * i;
            if (w < 12'd3072) begin
                exp_en++;
                if (q[ord[i]].we) ref_mem[w] = merge(ref_mem[w], q[ord[i]].dat, q[ord[i]].sel);
                else exp_d[ord[i]] = ref_mem[w];
            end
        end
        drive(0, q0); drive(1, q1);
        cap_en_cnt = 0; cap_ben = '0; cap_ad = '0; cap_di = '0; cap_rwb = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (sram_en) begin
                cap_en_cnt++; cap_ben = sram_ben; cap_ad = sram_ad; cap_di = sram_di; cap_rwb = sram_r_wb;
            end
            if (m0.ack) begin
                got_ack[0] = got_ack[0] < 0 ? c : 99; got_d[0] = m0.dat_r; m0.cyc = 1'b0; m0.stb = 1'b0;
            end
            if (m1.ack) begin
                got_ack[1] = got_ack[1] < 0 ? c : 99; got_d[1] = m1.dat_r; m1.cyc = 1'b0; m1.stb = 1'b0;
            end
            if (drop && c == 1) begin m0.cyc = 1'b0; m0.stb = 1'b0; end
        end
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("ack_cycle_m%0d", m), got_ack[m], exp_ack[m]);
            if (q[m].v && !q[m].we && exp_ack[m] > 0) chk($sformatf("rdata_m%0d", m), got_d[m], exp_d[m]);
        end
        chk("en_count", cap_en_cnt, exp_en);
        chk("idle_pins", {sram_en, sram_r_wb, |sram_ad, |sram_ben, |sram_di, |m0.dat_r, |m1.dat_r}, 0);
        last_d = got_d;
    endtask
    initial begin
        tbl[0]  = '{0, 1, 14'h0010, 4'hF, 32'hA5A5_1234, 1, 12'h004, 32'hFFFF_FFFF, 32'h0};
        tbl[1]  = '{0, 0, 14'h0010, 4'hF, 32'h0,         1, 12'h004, 32'hFFFF_FFFF, 32'hA5A5_1234};
        tbl[2]  = '{0, 1, 14'h0010, 4'hF, 32'hFFFF_FFFF, 1, 12'h004, 32'hFFFF_FFFF, 32'h0};
        tbl[3]  = '{1, 1, 14'h0010, 4'h2, 32'h0000_0000, 1, 12'h004, 32'h0000_FF00, 32'h0};
        tbl[4]  = '{1, 0, 14'h0010, 4'hF, 32'h0,         1, 12'h004, 32'hFFFF_FFFF, 32'hFFFF_00FF};
        tbl[5]  = '{0, 0, 14'h3000, 4'hF, 32'h0,         0, 12'hC00, 32'h0,         32'h0};
        tbl[6]  = '{1, 1, 14'h3000, 4'hF, 32'h1234_5678, 0, 12'hC00, 32'h0,         32'h0};
        tbl[7]  = '{0, 0, 14'h3FFC, 4'hF, 32'h0,         0, 12'hFFF, 32'h0,         32'h0};
        tbl[8]  = '{1, 1, 14'h2FFC, 4'h9, 32'hDEAD_BEEF, 1, 12'hBFF, 32'hFF00_00FF, 32'h0};
        tbl[9]  = '{1, 0, 14'h2FFC, 4'hF, 32'h0,         1, 12'hBFF, 32'hFFFF_FFFF, 32'hDE00_00EF};
        tbl[10] = '{0, 0, 14'h2FFE, 4'hF, 32'h0,         1, 12'hBFF, 32'hFFFF_FFFF, 32'hDE00_00EF};
        none = '{default: '0};
        drive(0, none); drive(1, none);
        @(posedge clk); #1;
        chk("reset_outputs", {m0.ack, m1.ack, sram_en, sram_r_wb, |sram_ad, |sram_ben, |sram_di, |m0.dat_r, |m1.dat_r}, 0);
        chk("reset_tieoffs", {sram_tm, sram_sm, sram_wlbi, sram_wloff}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // Both masters re-strobe one cycle after each ack; grant order follows the tie rule.
        r = '{v: 1, we: 0, adr: 14'h0, sel: 4'hF, dat: 32'h0};
        drive(0, r); drive(1, r);
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(posedge clk); #1;
            if (!m0.stb) begin m0.cyc = 1'b1; m0.stb = 1'b1; end
            if (!m1.stb) begin m1.cyc = 1'b1; m1.stb = 1'b1; end
            if (m0.ack || m1.ack) begin
                owner = m1.ack ? 1 : 0;
                chk($sformatf("grant_%0d", n), owner, FIXED ? 0 : n % 2);
                n++;
                if (m0.ack) begin m0.cyc = 1'b0; m0.stb = 1'b0; end
                if (m1.ack) begin m1.cyc = 1'b0; m1.stb = 1'b0; end
            end
        end
        chk("grant_count", n, 8);
        drive(0, none); drive(1, none);
        repeat (3) @(posedge clk);
        #1;
        m_last = FIXED ? 0 : 1;
        foreach (tbl[i]) begin
            r = '{v: 1, we: tbl[i].we, adr: tbl[i].adr, sel: tbl[i].sel, dat: tbl[i].dat};
            if (tbl[i].m) run(none, r, 0);
            else run(r, none, 0);
            chk($sformatf("vec%0d_en", i), cap_en_cnt, tbl[i].en);
            if (tbl[i].en) chk($sformatf("vec%0d_pins", i), {cap_rwb, cap_ad, cap_ben}, {~tbl[i].we, tbl[i].ad, tbl[i].ben});
            if (tbl[i].en && tbl[i].we) chk($sformatf("vec%0d_di", i), cap_di, tbl[i].dat);
            if (!tbl[i].we) chk($sformatf("vec%0d_rdata", i), last_d[tbl[i].m], tbl[i].rd);
        end
        r = '{v: 1, we: 1, adr: 14'h0040, sel: 4'hF, dat: 32'h5EED_0040};
        run(r, none, 1);
        r.we = 1'b0;
        run(r, none, 0);
        chk("drop_readback", last_d[0], 32'h5EED_0040);
        // Reset lands on the RESP edge of an m1 read.
        r = '{v: 1, we: 0, adr: 14'h0010, sel: 4'hF, dat: 32'h0};
        drive(1, r);
        @(posedge clk); #1;
        chk("rst_cmd_en", sram_en, 1);
        @(posedge clk); #1;
        chk("rst_resp_ack", m1.ack, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_ack", {m0.ack, m1.ack, sram_en}, 0);
        rst = 1'b0;
        drive(1, none);
        m_last = 1;
        @(posedge clk); #1;
        chk("rst_idle_quiet", {m0.ack, m1.ack, sram_en}, 0);
        r.adr = 14'h0;
        run(r, r, 0);
        for (int it = 0; it < 80; it++) begin
            a = rnd();
            b = rnd();
            run(a, b, 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
